// File: rtl/mux_scan_capture.sv
// Scan controller around a 4:1 bit mux: steps the select through channels 0..3,
// samples the mux output per channel and presents the assembled word on valid/ready.
module mux_scan_capture #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mux_o,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] data_out,
    output logic       valid,
    input  logic       ready
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    sel_r, sel_s;
    logic [2:0]    shadow_r, shadow_s;
    logic [3:0]    data_r, data_s;
    logic          valid_r, valid_s;
    logic          busy_r, busy_s;

    // State and output registers; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            sel_r    <= 2'b00;
            shadow_r <= 3'b000;
            data_r   <= 4'b0000;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            sel_r    <= sel_s;
            shadow_r <= shadow_s;
            data_r   <= data_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
        end
    end

    // Next-state and next-output logic for the scan sequence
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        sel_s    = sel_r;
        shadow_s = shadow_r;
        data_s   = data_r;
        valid_s  = valid_r;
        busy_s   = busy_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                    sel_s   = 2'b00;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                end else begin
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                end
            end
            SCAN: begin
                if (cnt_r == CNT_MAX) begin
                    cnt_s = '0;
                    if (sel_r == 2'd3) begin
                        // Last channel goes straight into the word, bypassing the shadow
                        data_s  = {mux_o, shadow_r};
                        valid_s = 1'b1;
                        busy_s  = 1'b0;
                        sel_s   = 2'b00;
                        state_s = DONE;
                    end else begin
                        case (sel_r)
                            2'd0:    shadow_s[0] = mux_o;
                            2'd1:    shadow_s[1] = mux_o;
                            2'd2:    shadow_s[2] = mux_o;
                            default: shadow_s    = shadow_r;
                        endcase
                        sel_s = sel_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            DONE: begin
                if (valid_r && ready) begin
                    valid_s = 1'b0;
                    if (start) begin
                        state_s = SCAN;
                        sel_s   = 2'b00;
                        cnt_s   = '0;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    sel_s = 2'b00;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                sel_s   = 2'b00;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign sel      = sel_r;
    assign busy     = busy_r;
    assign data_out = data_r;
    assign valid    = valid_r;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench: table of per-edge vectors against a SETTLE_CYCLES=1 instance,
// plus a hand-written dwell/mid-dwell-change sequence against a SETTLE_CYCLES=3 instance.
module tb_mux_scan_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with SETTLE_CYCLES = 1
    logic       rst1, start1, ready1;
    logic [3:0] a1;
    logic       mux1;
    logic [1:0] sel1;
    logic       busy1, valid1;
    logic [3:0] data1;

    // Instance with SETTLE_CYCLES = 3
    logic       rst3, start3, ready3;
    logic [3:0] a3;
    logic       mux3;
    logic [1:0] sel3;
    logic       busy3, valid3;
    logic [3:0] data3;

    assign mux1 = a1[sel1];
    assign mux3 = a3[sel3];

    mux_scan_capture #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .mux_o(mux1), .sel(sel1),
        .busy(busy1), .data_out(data1), .valid(valid1), .ready(ready1)
    );

    mux_scan_capture #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .mux_o(mux3), .sel(sel3),
        .busy(busy3), .data_out(data3), .valid(valid3), .ready(ready3)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       ready;
        logic [3:0] a;
        logic [1:0] sel;
        logic       busy;
        logic       valid;
        logic [3:0] data;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic s, input logic rd, input logic [3:0] a,
                       input logic [1:0] sl, input logic b, input logic v, input logic [3:0] d);
        vec_t t;
        t.rst = r; t.start = s; t.ready = rd; t.a = a;
        t.sel = sl; t.busy = b; t.valid = v; t.data = d;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b0; a1 = 4'b0000;
        rst3 = 1'b1; start3 = 1'b0; ready3 = 1'b0; a3 = 4'b0000;

        // Reset held with start high: nothing starts
        add(1'b1, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b0, 4'b0000);
        add(1'b1, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b0, 4'b0000);
        // Basic scan of 1010, then accept
        add(1'b0, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd1, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd2, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b1010);
        add(1'b0, 1'b0, 1'b1, 4'b1010, 2'd0, 1'b0, 1'b0, 4'b1010);
        // Rescan, then backpressure with start pulses ignored
        add(1'b0, 1'b1, 1'b0, 4'b1010, 2'd0, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd1, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd2, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b1010);
        for (int k = 0; k < 10; k++)
            add(1'b0, (k == 2 || k == 6), 1'b0, 4'b1010, 2'd0, 1'b0, 1'b1, 4'b1010);
        // Back-to-back: accept and restart on the same edge
        add(1'b0, 1'b1, 1'b1, 4'b0110, 2'd0, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b0110, 2'd1, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b0110, 2'd2, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b0110, 2'd3, 1'b1, 1'b0, 4'b1010);
        add(1'b0, 1'b0, 1'b0, 4'b0110, 2'd0, 1'b0, 1'b1, 4'b0110);
        add(1'b0, 1'b0, 1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 4'b0110);
        add(1'b0, 1'b0, 1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 4'b0110);
        // Reset mid-scan at sel = 2, then a fresh scan of 0011
        add(1'b0, 1'b1, 1'b0, 4'b0011, 2'd0, 1'b1, 1'b0, 4'b0110);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, 1'b1, 1'b0, 4'b0110);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd2, 1'b1, 1'b0, 4'b0110);
        add(1'b1, 1'b0, 1'b0, 4'b0011, 2'd0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd0, 1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b1, 1'b0, 4'b0011, 2'd0, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd1, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd2, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd3, 1'b1, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 1'b0, 4'b0011, 2'd0, 1'b0, 1'b1, 4'b0011);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst1 = vecs[i].rst; start1 = vecs[i].start;
            ready1 = vecs[i].ready; a1 = vecs[i].a;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d sel", i),   {2'b00, sel1},   {2'b00, vecs[i].sel});
            chk($sformatf("v%0d busy", i),  {3'b000, busy1}, {3'b000, vecs[i].busy});
            chk($sformatf("v%0d valid", i), {3'b000, valid1}, {3'b000, vecs[i].valid});
            chk($sformatf("v%0d data", i),  data1,           vecs[i].data);
        end

        // SETTLE_CYCLES = 3: dwell of 3 per channel, channel 2 input changes mid-dwell
        @(negedge clk);
        rst3 = 1'b1; start3 = 1'b1; a3 = 4'b1000;
        @(posedge clk);
        #1;
        chk("s3 reset valid", {3'b000, valid3}, 4'b0000);
        @(negedge clk);
        rst3 = 1'b0; start3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("s3 e%0d sel", k),   {2'b00, sel3},    4'(k / 3));
            chk($sformatf("s3 e%0d busy", k),  {3'b000, busy3},  4'b0001);
            chk($sformatf("s3 e%0d valid", k), {3'b000, valid3}, 4'b0000);
            @(negedge clk);
            start3 = 1'b0;
            if (k == 6) a3 = 4'b1100;
        end
        @(posedge clk);
        #1;
        chk("s3 done valid", {3'b000, valid3}, 4'b0001);
        chk("s3 done busy",  {3'b000, busy3},  4'b0000);
        chk("s3 done sel",   {2'b00, sel3},    4'b0000);
        chk("s3 done data",  data3,            4'b1100);
        @(negedge clk);
        ready3 = 1'b1;
        @(posedge clk);
        #1;
        chk("s3 accept valid", {3'b000, valid3}, 4'b0000);
        chk("s3 accept data",  data3,            4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
